// File: rtl/ext_unit_pkg.sv
// ext_unit_pkg: shared mode and state encodings
// for the operand-extension pipeline.
package ext_unit_pkg;

  localparam logic [2:0] EXT_SEXT  = 3'd0;
  localparam logic [2:0] EXT_ZEXT  = 3'd1;
  localparam logic [2:0] EXT_UPPER = 3'd2;
  localparam logic [2:0] EXT_BOFS  = 3'd3;
  localparam logic [2:0] EXT_LB    = 3'd4;
  localparam logic [2:0] EXT_LBU   = 3'd5;
  localparam logic [2:0] EXT_LH    = 3'd6;
  localparam logic [2:0] EXT_LHU   = 3'd7;

  typedef enum logic [1:0] {
    EXT_EMPTY = 2'd0,
    EXT_ONE   = 2'd1,
    EXT_FULL  = 2'd2
  } ext_state_e;

endpackage

// File: rtl/ext_unit_core.sv
// ext_unit_core: combinational mode/width datapath.
// Load lanes are built only with EXT_UNIT_LOAD_EN.
import ext_unit_pkg::*;

module ext_unit_core #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int OFS_W = $clog2(OUT_W/8)
) (
  input  logic [2:0]       mode,
  input  logic [OUT_W-1:0] in_data,
  input  logic [OFS_W-1:0] ofs,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] bofs;

  always_comb begin
    sext  = '0;
    zext  = '0;
    upper = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i < IN_W) begin
        sext[i] = in_data[i];
        zext[i] = in_data[i];
      end else begin
        sext[i] = in_data[IN_W-1];
      end
    end
    upper[OUT_W-1 -: IN_W] = in_data[IN_W-1:0];
  end

  assign bofs = sext << 2;

`ifdef EXT_UNIT_LOAD_EN
  logic [OFS_W-1:0] hofs;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [OUT_W-1:0] ld_b;
  logic [OUT_W-1:0] ld_h;
  logic             sgn;

  // misaligned halfword still reads the aligned lane
  assign hofs   = ofs >> 1;
  assign lane_b = 8'(in_data >> {ofs, 3'b000});
  assign lane_h = 16'(in_data >> {hofs, 4'b0000});
  assign sgn    = ~mode[0];

  always_comb begin
    ld_b = '0;
    ld_h = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i < 8) ld_b[i] = lane_b[i[2:0]];
      else       ld_b[i] = sgn & lane_b[7];
      if (i < 16) ld_h[i] = lane_h[i[3:0]];
      else        ld_h[i] = sgn & lane_h[15];
    end
  end
`else
  logic unused_in;
  assign unused_in = ^{ofs, in_data};
`endif

  always_comb begin
    data = sext;
    err  = 1'b0;
    unique case (1'b1)
      (mode == EXT_SEXT):  data = sext;
      (mode == EXT_ZEXT):  data = zext;
      (mode == EXT_UPPER): data = upper;
      (mode == EXT_BOFS):  data = bofs;
`ifdef EXT_UNIT_LOAD_EN
      (mode == EXT_LB),
      (mode == EXT_LBU):   data = ld_b;
      (mode == EXT_LH),
      (mode == EXT_LHU): begin
        data = ld_h;
        err  = ofs[0];
      end
`else
      mode[2]: begin
        data = sext;
        err  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered extension unit with a
// two-entry skid buffer. Load modes: EXT_UNIT_LOAD_EN.
import ext_unit_pkg::*;

module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int OFS_W = $clog2(OUT_W/8)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [OUT_W-1:0] in_data,
  input  logic [OFS_W-1:0] in_ofs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  ext_state_e       state;
  ext_state_e       state_n;
  logic [OUT_W-1:0] core_data;
  logic             core_err;
  logic [OUT_W-1:0] skid_data;
  logic             skid_err;
  logic             accept;
  logic             drain;
  logic             load0;
  logic             load1;
  logic             move;

  ext_unit_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .OFS_W (OFS_W)
  ) u_core (
    .mode    (in_mode),
    .in_data (in_data),
    .ofs     (in_ofs),
    .data    (core_data),
    .err     (core_err)
  );

  assign out_valid = (state != EXT_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_n = state;
    load0   = 1'b0;
    load1   = 1'b0;
    move    = 1'b0;
    unique case (state)
      EXT_EMPTY: begin
        if (accept) begin
          state_n = EXT_ONE;
          load0   = 1'b1;
        end
      end
      EXT_ONE: begin
        if (accept && drain) begin
          load0 = 1'b1;
        end else if (accept) begin
          state_n = EXT_FULL;
          load1   = 1'b1;
        end else if (drain) begin
          state_n = EXT_EMPTY;
        end
      end
      EXT_FULL: begin
        if (drain) begin
          state_n = EXT_ONE;
          move    = 1'b1;
        end
      end
      default: state_n = EXT_EMPTY;
    endcase
  end

  // in_ready tracks the next state so it never
  // depends combinationally on out_ready
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= EXT_EMPTY;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != EXT_FULL);
      if (load0) begin
        out_data <= core_data;
        out_err  <= core_err;
      end else if (move) begin
        out_data <= skid_data;
        out_err  <= skid_err;
      end
      if (load1) begin
        skid_data <= core_data;
        skid_err  <= core_err;
      end
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb_ext_unit_pipe: directed checks of modes,
// back-pressure and reset of ext_unit_pipe.
module tb_ext_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_data;
  logic [1:0]  in_ofs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int checks = 0;
  int passed = 0;

  ext_unit_pipe dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_ofs    (in_ofs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic op(input string tag,
                    input logic [2:0] m,
                    input logic [31:0] d,
                    input logic [1:0] o,
                    input logic [31:0] exp,
                    input logic e);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_ofs   = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_err"}, 32'(out_err), 32'(e));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 3'd0;
    in_data   = '0;
    in_ofs    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    op("sext", 3'd0, 32'h0000_8001, 2'd0,
       32'hFFFF_8001, 1'b0);
    op("zext", 3'd1, 32'h0000_8001, 2'd0,
       32'h0000_8001, 1'b0);
    op("sext_hi", 3'd0, 32'hABCD_0123, 2'd0,
       32'h0000_0123, 1'b0);
    op("upper", 3'd2, 32'h0000_1234, 2'd0,
       32'h1234_0000, 1'b0);
    op("bofs_n", 3'd3, 32'h0000_FFFF, 2'd0,
       32'hFFFF_FFFC, 1'b0);
    op("bofs_p", 3'd3, 32'h0000_7FFF, 2'd0,
       32'h0001_FFFC, 1'b0);
`ifdef EXT_UNIT_LOAD_EN
    op("lb3", 3'd4, 32'h80FF_7F01, 2'd3,
       32'hFFFF_FF80, 1'b0);
    op("lbu3", 3'd5, 32'h80FF_7F01, 2'd3,
       32'h0000_0080, 1'b0);
    op("lb0", 3'd4, 32'h80FF_7F01, 2'd0,
       32'h0000_0001, 1'b0);
    op("lh2", 3'd6, 32'h80FF_7F01, 2'd2,
       32'hFFFF_80FF, 1'b0);
    op("lhu2", 3'd7, 32'h80FF_7F01, 2'd2,
       32'h0000_80FF, 1'b0);
    op("lh1", 3'd6, 32'h80FF_7F01, 2'd1,
       32'h0000_7F01, 1'b1);
`else
    op("lbu_off", 3'd5, 32'h0000_00FF, 2'd0,
       32'h0000_00FF, 1'b1);
    op("lh_off", 3'd6, 32'h1111_8000, 2'd2,
       32'hFFFF_8000, 1'b1);
`endif
    @(posedge clk);
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);

    // back-pressure: four SEXT requests
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 3'd0;
    in_ofs    = 2'd0;
    in_data   = 32'h0000_8111;
    @(posedge clk);
    #1;
    chk("bp1_ready", 32'(in_ready), 32'd1);
    chk("bp1_data", out_data, 32'hFFFF_8111);
    @(negedge clk);
    in_data = 32'h0000_0222;
    @(posedge clk);
    #1;
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_data", out_data, 32'hFFFF_8111);
    @(negedge clk);
    in_data = 32'h0000_F333;
    @(posedge clk);
    #1;
    chk("bp3_ready", 32'(in_ready), 32'd0);
    chk("bp3_valid", 32'(out_valid), 32'd1);
    chk("bp3_hold", out_data, 32'hFFFF_8111);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("dr1_data", out_data, 32'h0000_0222);
    chk("dr1_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("dr2_data", out_data, 32'hFFFF_F333);
    @(negedge clk);
    in_data = 32'h0000_0444;
    @(posedge clk);
    #1;
    chk("dr3_data", out_data, 32'h0000_0444);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("dr_empty", 32'(out_valid), 32'd0);

    // reset while FULL
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h0000_0002;
    @(posedge clk);
    #1;
    chk("full_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    op("post_rst", 3'd0, 32'h0000_5555, 2'd0,
       32'h0000_5555, 1'b0);
    @(posedge clk);
    #1;
    chk("post_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ext_unit_pipe.md
# ext_unit_pipe

Parametrised, pipelined operand-extension unit for the pipelined MIPS datapath. Sits between decode/memory and the consumers of extended operands. Produces:
- sign/zero-extended immediates, LUI-style upper immediates and pre-shifted branch offsets;
- optionally, byte/halfword load-data extension.

Results are registered behind a valid/ready handshake with a two-entry skid buffer, so the unit sustains one result per cycle under back-pressure.

## Interface
Parameters:
- IN_W, 16, immediate width taken from in_data[IN_W-1:0]; 1 ≤ IN_W ≤ OUT_W
- OUT_W, 32, result width; a multiple of 16
- OFS_W, $clog2(OUT_W/8), byte-offset width (derived; do not override)

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- in_mode  in  3  operation select
- in_data  in  OUT_W  immediate (low IN_W bits) or load word
- in_ofs  in  OFS_W  byte offset for load modes
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  extended result
- out_err  out  1  result flagged (misaligned halfword or disabled mode)

## Operation
- Transfer occurs on a port when valid && ready at a rising edge.
- in_mode decode:
  - 000 SEXT: replicate in_data[IN_W-1].
  - 001 ZEXT: zero-fill.
  - 010 UPPER: in_data[IN_W-1:0] placed in the top IN_W bits; low bits zero.
  - 011 BOFS: SEXT result shifted left 2; bits shifted past OUT_W are dropped.
  - 100 LB / 101 LBU: byte lane in_ofs (little-endian, lane k = bits 8k+7:8k), sign/zero-extended.
  - 110 LH / 111 LHU: halfword lane in_ofs[OFS_W-1:1], sign/zero-extended.
- out_err = 1 for LH/LHU with in_ofs[0]=1. The data is still produced from the aligned halfword.
- Storage is a two-entry buffer:
  - Entry 0 is the output register, driving out_*.
  - Entry 1 is the skid register.
- State: EMPTY (no valid entries), ONE (entry 0 valid), FULL (both valid).
  - EMPTY, accept → ONE.
  - ONE, accept && !drain → FULL (new result into skid).
  - ONE, accept && drain → ONE (new result into entry 0).
  - ONE, drain && !accept → EMPTY.
  - FULL, drain → ONE (skid moves to entry 0). No accept is possible in FULL.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. Requests arriving while in_ready=0 are ignored.
- out_data/out_err hold their value while out_valid && !out_ready.
- Reset mid-operation discards both entries. In-flight results are lost, not replayed.

## Timing
- Reset values: out_valid 0, out_data 0, out_err 0, in_ready 1, state EMPTY.
- Latency is 1 cycle: a result accepted at edge N appears on out_* after edge N.
- Throughput is 1 per cycle while out_ready=1.
- After one stalled cycle in ONE with a new accept, in_ready deasserts the following cycle and reasserts the cycle after the first drain.
- No combinational path from out_ready to in_ready or from in_* to out_*.

## Configuration
- EXT_UNIT_LOAD_EN defined:
  - modes 1xx operate as above;
  - in_ofs is used.
- EXT_UNIT_LOAD_EN undefined:
  - the load-lane mux is not built; modes 1xx produce the SEXT result with out_err=1;
  - in_ofs is ignored;
  - the port list is unchanged.

## Structure
- Shared package ext_unit_pkg:
  - mode encoding constants EXT_SEXT … EXT_LHU;
  - state encoding EXT_EMPTY/EXT_ONE/EXT_FULL.
- One sub-module, ext_unit_core: purely combinational mode/width datapath (in_mode, in_data, in_ofs → data, err).
- The top holds the handshake, state machine and the two registers.

## Test plan
- Reset then SEXT in_data=0x0000_8001, out_ready=1 → out_data=0xFFFF_8001 one cycle later; ZEXT of same → 0x0000_8001.
- UPPER 0x1234 → 0x1234_0000; BOFS 0xFFFF → 0xFFFF_FFFC; BOFS 0x7FFF → 0x0001_FFFC.
- LOAD_EN: in_data=0x80FF_7F01:
  - LB ofs=3 → 0xFFFF_FF80; LBU ofs=3 → 0x0000_0080;
  - LH ofs=2 → 0xFFFF_80FF; LH ofs=1 → 0x0000_7F01 with out_err=1.
- Back-pressure: stream 4 SEXT requests with out_ready=0 from cycle 1 → in_ready falls after 2 accepts. Raise out_ready → all 4 results delivered in order with no loss or duplication.
- Assert Rst_n=0 while FULL → out_valid=0, in_ready=1 immediately. After release, the next request is delivered normally.
- LOAD_EN undefined: LBU 0x0000_00FF → out_data=0x0000_00FF (SEXT of low 16 bits), out_err=1.
